// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared definitions for the 8-register, 16-bit in-order pipeline and its
// hazard/flush controller.
package ex_hazard_ctrl_pkg;

  localparam int unsigned NUM_REGS       = 8;
  localparam int unsigned REG_IDX_W      = $clog2(NUM_REGS);
  localparam int unsigned WB_LATENCY_DEF = 3;
  localparam int unsigned RF_BYPASS_DEF  = 1;
  localparam int unsigned BR_PENALTY_DEF = 1;
  localparam int unsigned PERF_W         = 16;
  localparam int unsigned WORD_W         = 16;

  // Pipeline word field offsets (an all-zero word is the NOP bubble)
  localparam int unsigned WB_EN_BIT   = 4;
  localparam int unsigned WB_DEST_LSB = 1;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_AND = 4'h3,
    OP_OR  = 4'h4,
    OP_XOR = 4'h5,
    OP_SHL = 4'h6,
    OP_SHR = 4'h7,
    OP_LDI = 4'h8,
    OP_LD  = 4'h9,
    OP_ST  = 4'hA,
    OP_BZ  = 4'hB
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_SHL  = 3'd5,
    ALU_SHR  = 3'd6,
    ALU_PASS = 3'd7
  } alu_cmd_e;

  typedef enum logic {
    BRANCH_NONE = 1'b0,
    BRANCH_Z    = 1'b1
  } branch_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  function automatic logic word_wb_en(input logic [WORD_W-1:0] word);
    return word[WB_EN_BIT];
  endfunction

  function automatic reg_idx_t word_wb_dest(input logic [WORD_W-1:0] word);
    return word[WB_DEST_LSB +: REG_IDX_W];
  endfunction

endpackage

// File: rtl/ex_hazard_ctrl_if.sv
// ID-stage <-> sequencing-controller bundle: decoded ID fields in,
// pipeline control and perf counters out.
interface ex_hazard_ctrl_if;
  import ex_hazard_ctrl_pkg::*;

  logic              id_valid;
  reg_idx_t          id_src1;
  logic              id_src1_used;
  reg_idx_t          id_src2;
  logic              id_src2_used;
  logic              id_wb_en;
  reg_idx_t          id_dest;
  logic              id_branch_taken;

  logic              pc_stall;
  logic              if_id_stall;
  logic              if_id_flush;
  logic              id_ex_bubble;
  logic              issue;
  logic [PERF_W-1:0] stall_cycles;
  logic [PERF_W-1:0] flush_cycles;

  modport master (
    output id_valid, id_src1, id_src1_used, id_src2, id_src2_used,
           id_wb_en, id_dest, id_branch_taken,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_bubble, issue,
           stall_cycles, flush_cycles
  );

  modport slave (
    input  id_valid, id_src1, id_src1_used, id_src2, id_src2_used,
           id_wb_en, id_dest, id_branch_taken,
    output pc_stall, if_id_stall, if_id_flush, id_ex_bubble, issue,
           stall_cycles, flush_cycles
  );

endinterface

// File: rtl/ex_hazard_ctrl_scoreboard.sv
// Per-register count of cycles until an in-flight writeback lands; reports
// whether each of two source registers is still unsafe to read.
module ex_hazard_ctrl_scoreboard #(
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned WB_LATENCY = 3,
  parameter int unsigned RF_BYPASS  = 1,
  localparam int unsigned IDX_W     = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic [IDX_W-1:0] load_idx,
  input  logic [IDX_W-1:0] rd1_idx,
  input  logic [IDX_W-1:0] rd2_idx,
  output logic             busy1,
  output logic             busy2
);
  import ex_hazard_ctrl_pkg::*;

  localparam int unsigned CNT_W = $clog2(WB_LATENCY + 1);

  logic [CNT_W-1:0] cnt_q [NUM_REGS];

  // A fresh issue reloads the entry (WAW restart); otherwise count down to 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        if (load_en && (load_idx == IDX_W'(i))) begin
          cnt_q[i] <= CNT_W'(WB_LATENCY);
        end else if (cnt_q[i] != '0) begin
          cnt_q[i] <= cnt_q[i] - CNT_W'(1);
        end
      end
    end
  end

  // Write-before-read RF: a count at or below RF_BYPASS is already readable
  assign busy1 = (cnt_q[rd1_idx] > CNT_W'(RF_BYPASS));
  assign busy2 = (cnt_q[rd2_idx] > CNT_W'(RF_BYPASS));

endmodule

// File: rtl/ex_hazard_ctrl.sv
// Pipeline sequencing controller: RAW stall/bubble, taken-branch flush FSM
// and saturating stall/flush perf counters.
module ex_hazard_ctrl #(
  parameter int unsigned WB_LATENCY = ex_hazard_ctrl_pkg::WB_LATENCY_DEF,
  parameter int unsigned RF_BYPASS  = ex_hazard_ctrl_pkg::RF_BYPASS_DEF,
  parameter int unsigned BR_PENALTY = ex_hazard_ctrl_pkg::BR_PENALTY_DEF,
  parameter int unsigned NUM_REGS   = ex_hazard_ctrl_pkg::NUM_REGS
) (
  input  logic               clk,
  input  logic               rst,
  ex_hazard_ctrl_if.slave    hif
);
  import ex_hazard_ctrl_pkg::*;

  state_e            state_q, state_d;
  logic [1:0]        fl_q, fl_d;
  logic [PERF_W-1:0] stall_cnt_q, flush_cnt_q;

  logic busy1, busy2;
  logic run_c, hazard_c, issue_c, flush_c, bubble_c;

  ex_hazard_ctrl_scoreboard #(
    .NUM_REGS   (NUM_REGS),
    .WB_LATENCY (WB_LATENCY),
    .RF_BYPASS  (RF_BYPASS)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .load_en  (issue_c & hif.id_wb_en),
    .load_idx (hif.id_dest),
    .rd1_idx  (hif.id_src1),
    .rd2_idx  (hif.id_src2),
    .busy1    (busy1),
    .busy2    (busy2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      fl_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      fl_q    <= fl_d;
    end
  end

  // Hazard detection, issue decision and flush FSM next-state
  always_comb begin
    state_d  = state_q;
    fl_d     = fl_q;
    run_c    = (state_q == ST_RUN);
    hazard_c = run_c & hif.id_valid &
               ((hif.id_src1_used & busy1) | (hif.id_src2_used & busy2));
    issue_c  = run_c & hif.id_valid & ~hazard_c;
    flush_c  = ~run_c | (issue_c & hif.id_branch_taken);
    bubble_c = hazard_c | ~run_c | (run_c & ~hif.id_valid);

    unique case (state_q)
      ST_RUN: begin
        // With a one-cycle penalty the issue-cycle flush is all that is needed
        if (issue_c && hif.id_branch_taken && (BR_PENALTY > 1)) begin
          state_d = ST_FLUSH;
          fl_d    = 2'(BR_PENALTY - 1);
        end
      end
      ST_FLUSH: begin
        fl_d = fl_q - 2'd1;
        if (fl_q == 2'd1) begin
          state_d = ST_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (hazard_c && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + PERF_W'(1);
      end
      if (flush_c && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + PERF_W'(1);
      end
    end
  end

  // Control outputs are held quiet while reset is asserted
  assign hif.pc_stall     = hazard_c & ~rst;
  assign hif.if_id_stall  = hazard_c & ~rst;
  assign hif.if_id_flush  = flush_c  & ~rst;
  assign hif.id_ex_bubble = bubble_c & ~rst;
  assign hif.issue        = issue_c  & ~rst;
  assign hif.stall_cycles = stall_cnt_q;
  assign hif.flush_cycles = flush_cnt_q;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl: three instances (BR_PENALTY 1/2/3)
// share one ID stimulus stream.
module tb_ex_hazard_ctrl;
  import ex_hazard_ctrl_pkg::*;

  logic     clk = 1'b0;
  logic     rst;
  logic     id_valid, id_src1_used, id_src2_used, id_wb_en, id_branch_taken;
  reg_idx_t id_src1, id_src2, id_dest;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ex_hazard_ctrl_if if_a ();
  ex_hazard_ctrl_if if_b ();
  ex_hazard_ctrl_if if_c ();

  assign if_a.id_valid = id_valid;         assign if_b.id_valid = id_valid;         assign if_c.id_valid = id_valid;
  assign if_a.id_src1 = id_src1;           assign if_b.id_src1 = id_src1;           assign if_c.id_src1 = id_src1;
  assign if_a.id_src1_used = id_src1_used; assign if_b.id_src1_used = id_src1_used; assign if_c.id_src1_used = id_src1_used;
  assign if_a.id_src2 = id_src2;           assign if_b.id_src2 = id_src2;           assign if_c.id_src2 = id_src2;
  assign if_a.id_src2_used = id_src2_used; assign if_b.id_src2_used = id_src2_used; assign if_c.id_src2_used = id_src2_used;
  assign if_a.id_wb_en = id_wb_en;         assign if_b.id_wb_en = id_wb_en;         assign if_c.id_wb_en = id_wb_en;
  assign if_a.id_dest = id_dest;           assign if_b.id_dest = id_dest;           assign if_c.id_dest = id_dest;
  assign if_a.id_branch_taken = id_branch_taken;
  assign if_b.id_branch_taken = id_branch_taken;
  assign if_c.id_branch_taken = id_branch_taken;

  ex_hazard_ctrl #(.WB_LATENCY(3), .RF_BYPASS(1), .BR_PENALTY(1), .NUM_REGS(8))
    u_dut_a (.clk(clk), .rst(rst), .hif(if_a));
  ex_hazard_ctrl #(.WB_LATENCY(3), .RF_BYPASS(1), .BR_PENALTY(2), .NUM_REGS(8))
    u_dut_b (.clk(clk), .rst(rst), .hif(if_b));
  ex_hazard_ctrl #(.WB_LATENCY(3), .RF_BYPASS(1), .BR_PENALTY(3), .NUM_REGS(8))
    u_dut_c (.clk(clk), .rst(rst), .hif(if_c));

  task automatic drive(input logic v, input logic s1u, input int s1, input logic s2u,
                       input int s2, input logic wb, input int d, input logic bt);
    id_valid        = v;
    id_src1_used    = s1u;
    id_src1         = reg_idx_t'(s1);
    id_src2_used    = s2u;
    id_src2         = reg_idx_t'(s2);
    id_wb_en        = wb;
    id_dest         = reg_idx_t'(d);
    id_branch_taken = bt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    #1;
    n_cmp++; if (if_c.issue !== 1'b1) begin n_err++; $display("FAIL rst_br_issue: got %0b want 1", if_c.issue); end
    n_cmp++; if (if_c.if_id_flush !== 1'b1) begin n_err++; $display("FAIL rst_br_flush: got %0b want 1", if_c.if_id_flush); end
    tick();
    #1;
    n_cmp++; if (if_c.issue !== 1'b0) begin n_err++; $display("FAIL rst_flush_noissue: got %0b want 0", if_c.issue); end
    n_cmp++; if (if_c.id_ex_bubble !== 1'b1) begin n_err++; $display("FAIL rst_flush_bubble: got %0b want 1", if_c.id_ex_bubble); end
    tick();
    n_cmp++; if (if_c.flush_cycles !== 16'd2) begin n_err++; $display("FAIL rst_pre_flushcnt: got %0d want 2", if_c.flush_cycles); end
    n_cmp++; if (if_c.if_id_flush !== 1'b1) begin n_err++; $display("FAIL rst_still_flush: got %0b want 1", if_c.if_id_flush); end
    rst = 1'b1;
    #1;
    n_cmp++; if (if_c.if_id_flush !== 1'b0) begin n_err++; $display("FAIL rst_async_flush: got %0b want 0", if_c.if_id_flush); end
    n_cmp++; if (if_c.id_ex_bubble !== 1'b0) begin n_err++; $display("FAIL rst_async_bubble: got %0b want 0", if_c.id_ex_bubble); end
    n_cmp++; if (if_c.issue !== 1'b0) begin n_err++; $display("FAIL rst_async_issue: got %0b want 0", if_c.issue); end
    n_cmp++; if ({if_c.pc_stall, if_c.if_id_stall} !== 2'b00) begin n_err++; $display("FAIL rst_async_stall: got %0b want 0", {if_c.pc_stall, if_c.if_id_stall}); end
    n_cmp++; if (if_c.flush_cycles !== 16'd0) begin n_err++; $display("FAIL rst_async_flushcnt: got %0d want 0", if_c.flush_cycles); end
    n_cmp++; if (if_c.stall_cycles !== 16'd0) begin n_err++; $display("FAIL rst_async_stallcnt: got %0d want 0", if_c.stall_cycles); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    rst = 1'b0;
    #1;
    n_cmp++; if (if_c.id_ex_bubble !== 1'b1) begin n_err++; $display("FAIL rst_run_idle_bubble: got %0b want 1", if_c.id_ex_bubble); end
    n_cmp++; if (if_c.if_id_flush !== 1'b0) begin n_err++; $display("FAIL rst_run_noflush: got %0b want 0", if_c.if_id_flush); end
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    n_cmp++; if (if_c.issue !== 1'b1) begin n_err++; $display("FAIL rst_run_issue: got %0b want 1", if_c.issue); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    drive(1, 0, 0, 0, 0, 1, 1, 0);
    #1;
    n_cmp++; if (if_a.issue !== 1'b1) begin n_err++; $display("FAIL b2b_writer_issue: got %0b want 1", if_a.issue); end
    tick();
    drive(1, 1, 1, 0, 0, 0, 0, 0);
    for (int c = 0; c < 2; c++) begin
      #1;
      n_cmp++; if (if_a.pc_stall !== 1'b1) begin n_err++; $display("FAIL b2b_stall%0d: got %0b want 1", c, if_a.pc_stall); end
      n_cmp++; if ({if_a.issue, if_a.id_ex_bubble} !== 2'b01) begin n_err++; $display("FAIL b2b_bubble%0d: got %0b want 01", c, {if_a.issue, if_a.id_ex_bubble}); end
      tick();
    end
    #1;
    n_cmp++; if ({if_a.issue, if_a.pc_stall} !== 2'b10) begin n_err++; $display("FAIL b2b_issue3: got %0b want 10", {if_a.issue, if_a.pc_stall}); end
    tick();
    n_cmp++; if (if_a.stall_cycles !== 16'd2) begin n_err++; $display("FAIL b2b_stallcnt: got %0d want 2", if_a.stall_cycles); end
  endtask

  task automatic test_independent();
    apply_reset();
    drive(1, 0, 0, 0, 0, 1, 1, 0);
    tick();
    drive(1, 1, 2, 1, 3, 0, 0, 0);
    #1;
    n_cmp++; if ({if_a.issue, if_a.pc_stall} !== 2'b10) begin n_err++; $display("FAIL ind_r2r3_a: got %0b want 10", {if_a.issue, if_a.pc_stall}); end
    tick();
    drive(1, 1, 3, 1, 2, 1, 5, 0);
    #1;
    n_cmp++; if ({if_a.issue, if_a.pc_stall} !== 2'b10) begin n_err++; $display("FAIL ind_r3r2_b: got %0b want 10", {if_a.issue, if_a.pc_stall}); end
    tick();
    drive(1, 0, 0, 1, 1, 0, 0, 0);
    #1;
    n_cmp++; if (if_a.issue !== 1'b1) begin n_err++; $display("FAIL ind_bypass_edge: got %0b want 1", if_a.issue); end
    tick();
    n_cmp++; if (if_a.stall_cycles !== 16'd0) begin n_err++; $display("FAIL ind_stallcnt: got %0d want 0", if_a.stall_cycles); end
  endtask

  task automatic test_waw();
    apply_reset();
    drive(1, 0, 0, 0, 0, 1, 4, 0);
    tick();
    #1;
    n_cmp++; if (if_a.issue !== 1'b1) begin n_err++; $display("FAIL waw_second_issue: got %0b want 1", if_a.issue); end
    tick();
    drive(1, 0, 0, 1, 4, 0, 0, 0);
    for (int c = 0; c < 2; c++) begin
      #1;
      n_cmp++; if (if_a.if_id_stall !== 1'b1) begin n_err++; $display("FAIL waw_stall%0d: got %0b want 1", c, if_a.if_id_stall); end
      tick();
    end
    #1;
    n_cmp++; if (if_a.issue !== 1'b1) begin n_err++; $display("FAIL waw_reader_issue: got %0b want 1", if_a.issue); end
    tick();
    n_cmp++; if (if_a.stall_cycles !== 16'd2) begin n_err++; $display("FAIL waw_stallcnt: got %0d want 2", if_a.stall_cycles); end
  endtask

  task automatic test_branch();
    apply_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    #1;
    n_cmp++; if ({if_b.issue, if_b.if_id_flush, if_b.id_ex_bubble} !== 3'b110) begin n_err++; $display("FAIL br_issue_cycle: got %03b want 110", {if_b.issue, if_b.if_id_flush, if_b.id_ex_bubble}); end
    tick();
    #1;
    n_cmp++; if ({if_b.issue, if_b.if_id_flush, if_b.id_ex_bubble} !== 3'b011) begin n_err++; $display("FAIL br_flush_cycle: got %03b want 011", {if_b.issue, if_b.if_id_flush, if_b.id_ex_bubble}); end
    n_cmp++; if (if_a.issue !== 1'b1) begin n_err++; $display("FAIL br_pen1_stays_run: got %0b want 1", if_a.issue); end
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    n_cmp++; if ({if_b.issue, if_b.if_id_flush} !== 2'b10) begin n_err++; $display("FAIL br_back_to_run: got %0b want 10", {if_b.issue, if_b.if_id_flush}); end
    n_cmp++; if (if_b.flush_cycles !== 16'd2) begin n_err++; $display("FAIL br_flushcnt: got %0d want 2", if_b.flush_cycles); end
  endtask

  task automatic test_stalled_branch();
    apply_reset();
    drive(1, 0, 0, 0, 0, 1, 2, 0);
    tick();
    drive(1, 1, 2, 0, 0, 0, 0, 1);
    for (int c = 0; c < 2; c++) begin
      #1;
      n_cmp++; if ({if_a.pc_stall, if_a.if_id_flush, if_a.issue} !== 3'b100) begin n_err++; $display("FAIL sbr_stall%0d: got %03b want 100", c, {if_a.pc_stall, if_a.if_id_flush, if_a.issue}); end
      tick();
    end
    #1;
    n_cmp++; if ({if_a.issue, if_a.if_id_flush} !== 2'b11) begin n_err++; $display("FAIL sbr_issue_flush: got %0b want 11", {if_a.issue, if_a.if_id_flush}); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    n_cmp++; if (if_a.if_id_flush !== 1'b0) begin n_err++; $display("FAIL sbr_after_flush: got %0b want 0", if_a.if_id_flush); end
    n_cmp++; if (if_a.flush_cycles !== 16'd1) begin n_err++; $display("FAIL sbr_flushcnt: got %0d want 1", if_a.flush_cycles); end
    n_cmp++; if (if_a.stall_cycles !== 16'd2) begin n_err++; $display("FAIL sbr_stallcnt: got %0d want 2", if_a.stall_cycles); end
  endtask

  task automatic test_saturation();
    drive(1, 0, 0, 0, 0, 1, 3, 0);
    tick();
    force u_dut_a.stall_cnt_q = 16'hFFFE;
    #1;
    release u_dut_a.stall_cnt_q;
    drive(1, 1, 3, 0, 0, 0, 0, 0);
    #1;
    n_cmp++; if (if_a.pc_stall !== 1'b1) begin n_err++; $display("FAIL sat_stall: got %0b want 1", if_a.pc_stall); end
    tick();
    n_cmp++; if (if_a.stall_cycles !== 16'hFFFF) begin n_err++; $display("FAIL sat_reach: got %0h want ffff", if_a.stall_cycles); end
    tick();
    n_cmp++; if (if_a.stall_cycles !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold: got %0h want ffff", if_a.stall_cycles); end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    n_cmp++; if ({if_a.issue, if_a.id_ex_bubble, if_a.if_id_flush, if_a.pc_stall} !== 4'b0000) begin n_err++; $display("FAIL init_reset_outputs: got %04b want 0000", {if_a.issue, if_a.id_ex_bubble, if_a.if_id_flush, if_a.pc_stall}); end
    tick();
    test_reset();
    test_back_to_back();
    test_independent();
    test_waw();
    test_branch();
    test_stalled_branch();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
